// File: rtl/std_fp_mult_arbiter.sv
// std_fp_mult_arbiter: shares one fixed-point multiplier pipeline among
// NUM_REQ go/done requesters with work-conserving round-robin arbitration.
//
// Requester handshake (go/done):
//   A requester raises go[i] with its operands valid on left/right and holds
//   go[i] high until done[i] pulses for exactly one cycle. It drops go[i] in
//   the cycle after done. out carries the product only while a done bit is
//   high. A go that stays high into a following IDLE is treated as a new
//   request.
//
// The file also contains std_fp_mult_pipe, the shared multiplier.

// std_fp_mult_pipe: unsigned fixed-point multiply with go/done handshake.
// go must be held high until done. Dropping go for one cycle clears the
// sequencing counter, so the next operation starts from a clean pipeline.
// done rises in the fourth consecutive cycle that go is high.
module std_fp_mult_pipe #(
    parameter int WIDTH      = 32,
    parameter int INT_WIDTH  = 16,
    parameter int FRAC_WIDTH = 16
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             go,
    input  logic [WIDTH-1:0] left,
    input  logic [WIDTH-1:0] right,
    output logic [WIDTH-1:0] out,
    output logic             done
);
    // The product keeps integer and fraction bits centred on the binary point.
    localparam int SHIFT = WIDTH - INT_WIDTH;

    // Elaboration-time check that the fixed-point format adds up.
    generate
        if (INT_WIDTH + FRAC_WIDTH != WIDTH) begin : g_fmt_check
            $error("std_fp_mult_pipe: INT_WIDTH + FRAC_WIDTH must equal WIDTH");
        end
    endgenerate

    logic [1:0]       cnt_q, cnt_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic [WIDTH-1:0] prod_q, prod_d;
    logic [WIDTH-1:0] res_q, res_d;

    // Sequence the three pipeline stages off a counter that go=0 clears.
    always_comb begin
        cnt_d  = cnt_q;
        a_d    = a_q;
        b_d    = b_q;
        prod_d = prod_q;
        res_d  = res_q;
        if (!go) begin
            cnt_d = 2'd0;
        end else if (cnt_q != 2'd3) begin
            cnt_d = cnt_q + 2'd1;
        end
        if (go && cnt_q == 2'd0) begin
            a_d = left;
            b_d = right;
        end
        if (go && cnt_q == 2'd1) begin
            // Full-width product, then keep the window around the binary
            // point; integer overflow wraps.
            prod_d = WIDTH'(((2*WIDTH)'(a_q) * (2*WIDTH)'(b_q)) >> SHIFT);
        end
        if (go && cnt_q == 2'd2) begin
            res_d = prod_q;
        end
    end

    // Pipeline registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            cnt_q  <= 2'd0;
            a_q    <= '0;
            b_q    <= '0;
            prod_q <= '0;
            res_q  <= '0;
        end else begin
            cnt_q  <= cnt_d;
            a_q    <= a_d;
            b_q    <= b_d;
            prod_q <= prod_d;
            res_q  <= res_d;
        end
    end

    assign out  = res_q;
    assign done = (cnt_q == 2'd3);
endmodule

// std_fp_mult_arbiter: round-robin front end for std_fp_mult_pipe.
// IDLE arbitrates from the pointer. BUSY runs the multiplier on registered
// operands. DONE pulses done[grant] with mult go low to flush the pipe, and
// arbitrates among the other requesters so back-to-back service has no idle gap.
module std_fp_mult_arbiter #(
    parameter int WIDTH      = 32,
    parameter int INT_WIDTH  = 16,
    parameter int FRAC_WIDTH = 16,
    parameter int NUM_REQ    = 4,
    localparam int IDX_W     = $clog2(NUM_REQ)
) (
    input  logic                     clk,
    input  logic                     reset_n,
    input  logic [NUM_REQ-1:0]       go,
    input  logic [NUM_REQ*WIDTH-1:0] left,
    input  logic [NUM_REQ*WIDTH-1:0] right,
    output logic [WIDTH-1:0]         out,
    output logic [NUM_REQ-1:0]       done,
    output logic                     busy,
    output logic [IDX_W-1:0]         grant,
    output logic [1:0]               dbg_state
);
    generate
        if (NUM_REQ < 2 || NUM_REQ > 8) begin : g_req_check
            $error("std_fp_mult_arbiter: NUM_REQ must be in 2..8");
        end
    endgenerate

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_BUSY = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [IDX_W-1:0] ptr_q, ptr_d;
    logic [IDX_W-1:0] grant_q, grant_d;
    logic [WIDTH-1:0] op_l_q, op_l_d;
    logic [WIDTH-1:0] op_r_q, op_r_d;
    logic [WIDTH-1:0] out_q, out_d;

    logic [NUM_REQ-1:0] req_m;
    logic [NUM_REQ-1:0] excl;
    logic [IDX_W-1:0]   start_idx;
    logic [IDX_W-1:0]   next_idx;
    logic               win_valid;
    logic [IDX_W-1:0]   win_idx;
    logic [WIDTH-1:0]   win_left;
    logic [WIDTH-1:0]   win_right;

    logic               mult_go;
    logic               mult_done;
    logic [WIDTH-1:0]   mult_out;

    // First set bit of req at or after start, scanning cyclically.
    // Returns {found, index}.
    function automatic logic [IDX_W:0] rr_pick(
        input logic [NUM_REQ-1:0] req,
        input logic [IDX_W-1:0]   start
    );
        logic             found;
        logic [IDX_W-1:0] idx;
        int               c;
        found = 1'b0;
        idx   = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            c = int'(start) + k;
            if (c >= NUM_REQ) begin
                c = c - NUM_REQ;
            end
            if (!found && req[c]) begin
                found = 1'b1;
                idx   = IDX_W'(c);
            end
        end
        return {found, idx};
    endfunction

    // Arbitration: from the pointer in IDLE, or from grant+1 in DONE with the
    // finishing requester masked so its still-high go is not re-granted.
    always_comb begin
        next_idx = (grant_q == IDX_W'(NUM_REQ - 1)) ? '0 : grant_q + IDX_W'(1);
        excl = '0;
        excl[grant_q] = 1'b1;
        if (state_q == S_DONE) begin
            req_m     = go & ~excl;
            start_idx = next_idx;
        end else begin
            req_m     = go;
            start_idx = ptr_q;
        end
        {win_valid, win_idx} = rr_pick(req_m, start_idx);
        win_left  = left[int'(win_idx)*WIDTH +: WIDTH];
        win_right = right[int'(win_idx)*WIDTH +: WIDTH];
    end

    // Next-state and output logic for IDLE / BUSY / DONE.
    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        grant_d = grant_q;
        op_l_d  = op_l_q;
        op_r_d  = op_r_q;
        out_d   = out_q;
        done    = '0;
        case (state_q)
            S_IDLE: begin
                if (win_valid) begin
                    grant_d = win_idx;
                    op_l_d  = win_left;
                    op_r_d  = win_right;
                    state_d = S_BUSY;
                end
            end
            S_BUSY: begin
                if (mult_done) begin
                    out_d   = mult_out;
                    state_d = S_DONE;
                end
            end
            S_DONE: begin
                done[grant_q] = 1'b1;
                ptr_d = next_idx;
                if (win_valid) begin
                    grant_d = win_idx;
                    op_l_d  = win_left;
                    op_r_d  = win_right;
                    state_d = S_BUSY;
                end else begin
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State and datapath registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q <= S_IDLE;
            ptr_q   <= '0;
            grant_q <= '0;
            op_l_q  <= '0;
            op_r_q  <= '0;
            out_q   <= '0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            grant_q <= grant_d;
            op_l_q  <= op_l_d;
            op_r_q  <= op_r_d;
            out_q   <= out_d;
        end
    end

    // Reset gates mult go in the same cycle so an aborted op clears at once.
    assign mult_go = reset_n && (state_q == S_BUSY);

    std_fp_mult_pipe #(
        .WIDTH      (WIDTH),
        .INT_WIDTH  (INT_WIDTH),
        .FRAC_WIDTH (FRAC_WIDTH)
    ) u_mult (
        .clk     (clk),
        .reset_n (reset_n),
        .go      (mult_go),
        .left    (op_l_q),
        .right   (op_r_q),
        .out     (mult_out),
        .done    (mult_done)
    );

    assign out       = out_q;
    assign busy      = (state_q != S_IDLE);
    assign grant     = grant_q;
    assign dbg_state = state_q;
endmodule

// File: tb/tb_std_fp_mult_arbiter.sv
// Testbench for std_fp_mult_arbiter (WIDTH=32, Q16.16, NUM_REQ=4).
// Directed vectors with hand-computed products; a forked monitor pops the
// expected queue whenever a done bit pulses.
module tb_std_fp_mult_arbiter;
  localparam int W  = 32;
  localparam int NR = 4;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk = ~clk;

  logic [NR-1:0]   go;
  logic [NR*W-1:0] left;
  logic [NR*W-1:0] right;
  logic [W-1:0]    out;
  logic [NR-1:0]   done;
  logic            busy;
  logic [1:0]      grant;
  logic [1:0]      dbg_state;

  std_fp_mult_arbiter #(
    .WIDTH(W), .INT_WIDTH(16), .FRAC_WIDTH(16), .NUM_REQ(NR)
  ) dut (
    .clk(clk), .reset_n(reset_n), .go(go), .left(left), .right(right),
    .out(out), .done(done), .busy(busy), .grant(grant), .dbg_state(dbg_state)
  );

  // ---------------- scoreboard ----------------
  int errors = 0;
  int checks = 0;
  logic [W-1:0] exp_q[$];
  int           exp_idx_q[$];

  // Fairness products, in expected service order: left=(i+1).0, right=(k+1).5
  logic [W-1:0] fair_exp [12] = '{
    32'h0001_8000, 32'h0003_0000, 32'h0004_8000, 32'h0006_0000,
    32'h0002_8000, 32'h0005_0000, 32'h0007_8000, 32'h000A_0000,
    32'h0003_8000, 32'h0007_0000, 32'h000A_8000, 32'h000E_0000
  };

  task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic expect_op(input int idx, input logic [W-1:0] val);
    exp_q.push_back(val);
    exp_idx_q.push_back(idx);
  endtask

  // Monitor: every done pulse is checked against the head of the queue.
  task automatic monitor();
    logic [W-1:0] e;
    int ei;
    int di;
    forever begin
      @(negedge clk);
      if (done !== '0) begin
        check("done_onehot", 32'($countones(done)), 32'd1);
        check("busy_in_done", 32'(busy), 32'd1);
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_done: done=%b out=%h, nothing expected", done, out);
        end else begin
          e  = exp_q.pop_front();
          ei = exp_idx_q.pop_front();
          di = 0;
          for (int k = 0; k < NR; k++) if (done[k]) di = k;
          check("done_idx", 32'(di), 32'(ei));
          check("out", out, e);
        end
      end
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic do_reset();
    reset_n = 1'b0;
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
  endtask

  // One go/done transaction for requester i. exp_lat=0 skips the latency
  // check; chg rewrites the left operand in the second BUSY cycle.
  task automatic do_op(input int i, input logic [W-1:0] l, input logic [W-1:0] r,
                       input int exp_lat, input bit chg, input logic [W-1:0] l2);
    int cyc;
    bit seen;
    left[i*W +: W]  = l;
    right[i*W +: W] = r;
    go[i] = 1'b1;
    cyc  = 0;
    seen = 1'b0;
    while (!seen && cyc < 60) begin
      @(negedge clk);
      cyc++;
      if (chg && cyc == 2) left[i*W +: W] = l2;
      if (done[i]) seen = 1'b1;
    end
    if (!seen) begin
      checks++;
      errors++;
      $display("FAIL timeout_req%0d: no done within %0d cycles, expected one", i, cyc);
    end else if (exp_lat != 0) begin
      check($sformatf("latency_req%0d", i), 32'(cyc), 32'(exp_lat));
    end
    @(negedge clk);
    go[i] = 1'b0;
    @(negedge clk);
  endtask

  task automatic fair_req(input int i);
    for (int k = 0; k < 3; k++) begin
      do_op(i, 32'((i + 1) << 16), 32'(((k + 1) << 16) | 32'h8000), 0, 1'b0, '0);
    end
  endtask

  // ---------------- main sequence ----------------
  initial begin
    go    = '0;
    left  = '0;
    right = '0;
    fork
      monitor();
    join_none

    // Reset state
    repeat (3) @(negedge clk);
    check("rst_done", 32'(done), 32'd0);
    check("rst_out", out, 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_grant", 32'(grant), 32'd0);
    check("rst_state", 32'(dbg_state), 32'd0);
    reset_n = 1'b1;
    @(negedge clk);

    // 1. Single op: 2.5 * 1.5 = 3.75
    expect_op(0, 32'h0003_C000);
    do_op(0, 32'h0002_8000, 32'h0001_8000, 5, 1'b0, '0);

    // 2. Integer overflow wraps: 256.0 * 256.0 -> 0
    expect_op(2, 32'h0000_0000);
    do_op(2, 32'h0100_0000, 32'h0100_0000, 5, 1'b0, '0);

    // 3. Contention from pointer 0: req0 then req1 with no idle gap
    do_reset();
    expect_op(0, 32'h0003_0000);
    expect_op(1, 32'h0004_8000);
    fork
      do_op(0, 32'h0001_0000, 32'h0003_0000, 5, 1'b0, '0);
      do_op(1, 32'h0002_0000, 32'h0002_4000, 10, 1'b0, '0);
      begin
        repeat (7) @(negedge clk);
        check("contend_grant", 32'(grant), 32'd1);
        check("contend_state_busy", 32'(dbg_state), 32'd1);
      end
    join

    // 4. Fairness: all four re-request for 12 ops
    do_reset();
    for (int n = 0; n < 12; n++) expect_op(n % 4, fair_exp[n]);
    fork
      fair_req(0);
      fair_req(1);
      fair_req(2);
      fair_req(3);
    join

    // 5. Reset in the second BUSY cycle of req3; go[3] held throughout
    expect_op(3, 32'h0002_0000);
    left[3*W +: W]  = 32'h0004_0000;
    right[3*W +: W] = 32'h0000_8000;
    go[3] = 1'b1;
    @(negedge clk);
    @(negedge clk);
    reset_n = 1'b0;
    check("abort_no_done_c2", 32'(done), 32'd0);
    @(negedge clk);
    check("abort_busy", 32'(busy), 32'd0);
    check("abort_grant", 32'(grant), 32'd0);
    check("abort_no_done_c3", 32'(done), 32'd0);
    reset_n = 1'b1;
    for (int c = 4; c <= 7; c++) begin
      @(negedge clk);
      check($sformatf("abort_no_done_c%0d", c), 32'(done), 32'd0);
    end
    @(negedge clk);
    check("abort_redo_done", 32'(done), 32'b1000);
    @(negedge clk);
    go[3] = 1'b0;
    @(negedge clk);

    // 6. Operand change during BUSY is ignored: 2.0 * 3.0 = 6.0
    expect_op(1, 32'h0006_0000);
    do_op(1, 32'h0002_0000, 32'h0003_0000, 5, 1'b1, 32'hFFFF_0000);

    repeat (5) @(negedge clk);
    check("queue_empty", 32'(exp_q.size()), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
